// File: rtl/md_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package md_ctrl_pkg;

  localparam int MD_OP_W    = 4;
  localparam int MD_CNT_W   = 4;
  localparam int MD_MUL_CYC = 5;
  localparam int MD_DIV_CYC = 10;

  // E-stage MDU op codes; 9-15 decode to nothing and behave as NONE.
  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_ctrl_if.sv
// Pipeline <-> MDU controller signal bundle.
// Latency: n/a (wires only).
// Backpressure: stall_req flows back to the hazard unit; no valid/ready here.
interface md_ctrl_if;
  import md_ctrl_pkg::*;

  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               d_uses_md;
  logic               busy;
  logic               stall_req;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        md_out;

  // Pipeline side: issues ops and operands, observes status and results.
  modport master (
    output md_op, rs_val, rt_val, d_uses_md,
    input  busy, stall_req, hi, lo, md_out
  );

  // Controller side.
  modport slave (
    input  md_op, rs_val, rt_val, d_uses_md,
    output busy, stall_req, hi, lo, md_out
  );

endinterface

// File: rtl/md_ctrl_arith.sv
// Combinational MDU datapath: 64-bit products and (with MD_DIV_EN) quotient/remainder.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the controller decides when the result is captured.
module md_arith
  import md_ctrl_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [63:0]        res,
  output logic               dz
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MD_DIV_EN
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Divider; a zero divisor yields 0 here and is flagged through dz instead.
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (b != 32'd0) begin
      quo_s = $signed(a) / $signed(b);
      rem_s = $signed(a) % $signed(b);
      quo_u = a / b;
      rem_u = a % b;
    end
  end
`endif

  // Result select: {HI, LO} layout, i.e. {remainder, quotient} for divides.
  always_comb begin
    res = '0;
    dz  = 1'b0;
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
`ifdef MD_DIV_EN
      MD_DIV: begin
        res = {rem_s, quo_s};
        dz  = (b == 32'd0);
      end
      MD_DIVU: begin
        res = {rem_u, quo_u};
        dz  = (b == 32'd0);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// MDU controller: HI/LO registers, fixed-latency MUL/DIV sequencing (DIV only with MD_DIV_EN).
// Latency: MULT* busy 5 cycles, DIV* busy 10 cycles, HI/LO written on the last busy edge; MT* 1 edge.
// Backpressure: stall_req = d_uses_md & (start | busy); ops arriving while busy are dropped.
module md_ctrl
  import md_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  md_ctrl_if.slave md
);

  md_state_e           state_q;
  md_state_e           state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [63:0]         res_q;
  logic                dz_q;
  logic [31:0]         hi_q;
  logic [31:0]         lo_q;
  logic [63:0]         arith_res;
  logic                arith_dz;
  logic                start;
  logic                start_div;
  logic                busy;
  logic                done;

  md_arith u_arith (
    .op  (md.md_op),
    .a   (md.rs_val),
    .b   (md.rt_val),
    .res (arith_res),
    .dz  (arith_dz)
  );

  // Start decode: only accepted from IDLE; DIV/DIVU decode to nothing without the divider.
  always_comb begin
    start     = 1'b0;
    start_div = 1'b0;
    if (state_q == ST_IDLE) begin
      case (md.md_op)
        MD_MULT, MD_MULTU: start = 1'b1;
`ifdef MD_DIV_EN
        MD_DIV, MD_DIVU: begin
          start     = 1'b1;
          start_div = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign done = (state_q != ST_IDLE) && (cnt_q == MD_CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on start, return once the counter reaches its last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = start_div ? ST_DIV : ST_MUL;
      ST_MUL,
      ST_DIV:  if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and read-data mux.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    md.busy      = busy;
    md.stall_req = md.d_uses_md & (start | busy);
    md.hi        = hi_q;
    md.lo        = lo_q;
    case (md.md_op)
      MD_MFHI: md.md_out = hi_q;
      MD_MFLO: md.md_out = lo_q;
      default: md.md_out = '0;
    endcase
  end

  // Busy-cycle counter: loaded on start, counts down through the busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (start)
      cnt_q <= start_div ? MD_CNT_W'(MD_DIV_CYC) : MD_CNT_W'(MD_MUL_CYC);
    else if (busy)
      cnt_q <= cnt_q - MD_CNT_W'(1);
  end

  // Result capture at start; the op's sign mode is already folded into the captured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      dz_q  <= 1'b0;
    end else if (start) begin
      res_q <= arith_res;
      dz_q  <= arith_dz;
    end
  end

  // HI/LO: commit the captured result on the last busy edge, MT* writes only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (!dz_q) begin
        hi_q <= res_q[63:32];
        lo_q <= res_q[31:0];
      end
    end else if (state_q == ST_IDLE) begin
      if (md.md_op == MD_MTHI) hi_q <= md.rs_val;
      if (md.md_op == MD_MTLO) lo_q <= md.rs_val;
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl; expectations follow the MD_DIV_EN setting of the build.
// Latency: inputs driven 2 time units after posedge, outputs sampled at negedge.
// Backpressure: n/a.
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  exp_t sbq[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_ctrl_if mif ();

  md_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one op, count busy cycles, then check HI/LO and MFHI/MFLO read-back.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit do_step, input bit intrude);
    exp_t e;
    int   cnt;
    e.hi = ehi;
    e.lo = elo;
    sbq.push_back(e);
    if (do_step) step();
    mif.md_op     = op;
    mif.rs_val    = a;
    mif.rt_val    = b;
    mif.d_uses_md = 1'b1;
    @(negedge clk);
    chk({tag, ".c0_busy"}, 32'(mif.busy), 32'd0);
    chk({tag, ".c0_stall"}, 32'(mif.stall_req), 32'(exp_busy != 0));
    cnt = 0;
    forever begin
      step();
      if (intrude && cnt == 2) begin
        mif.md_op  = MD_MTHI;
        mif.rs_val = 32'hDEADBEEF;
      end else begin
        mif.md_op = MD_NONE;
      end
      @(negedge clk);
      if (!mif.busy) break;
      cnt++;
      chk({tag, ".busy_stall"}, 32'(mif.stall_req), 32'd1);
      if (cnt > 40) begin
        chk({tag, ".timeout"}, 32'(cnt), 32'(exp_busy));
        break;
      end
    end
    chk({tag, ".busy_cycles"}, 32'(cnt), 32'(exp_busy));
    chk({tag, ".done_stall"}, 32'(mif.stall_req), 32'd0);
    e = sbq.pop_front();
    chk({tag, ".hi"}, mif.hi, e.hi);
    chk({tag, ".lo"}, mif.lo, e.lo);
    mif.md_op = MD_MFLO;
    #1;
    chk({tag, ".mflo"}, mif.md_out, e.lo);
    mif.md_op = MD_MFHI;
    #1;
    chk({tag, ".mfhi"}, mif.md_out, e.hi);
    mif.md_op     = MD_NONE;
    mif.d_uses_md = 1'b0;
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  initial begin
    logic [31:0]     ra;
    logic [31:0]     rb;
    int              sa;
    int              sb;
    longint          ps;
    longint unsigned pu;
    logic [3:0]      abort_op;
    int              div_busy;

    n_chk  = 0;
    n_fail = 0;
    m_hi   = '0;
    m_lo   = '0;
`ifdef MD_DIV_EN
    div_busy = 10;
    abort_op = MD_DIV;
`else
    div_busy = 0;
    abort_op = MD_MULT;
`endif

    mif.md_op     = MD_NONE;
    mif.rs_val    = '0;
    mif.rt_val    = '0;
    mif.d_uses_md = 1'b0;
    rst_n         = 1'b0;

    // Reset state
    step();
    @(negedge clk);
    chk("rst.busy", 32'(mif.busy), 32'd0);
    chk("rst.stall", 32'(mif.stall_req), 32'd0);
    chk("rst.hi", mif.hi, 32'd0);
    chk("rst.lo", mif.lo, 32'd0);
    chk("rst.md_out", mif.md_out, 32'd0);

    // Release and start MULT on the very first edge: -2 * 3
    step();
    rst_n = 1'b1;
    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0);

    // MULTU 0xFFFFFFFF * 2
    run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);

    // MTHI then MFHI next cycle
    step();
    mif.md_op     = MD_MTHI;
    mif.rs_val    = 32'h12345678;
    mif.d_uses_md = 1'b1;
    @(negedge clk);
    chk("mthi.busy", 32'(mif.busy), 32'd0);
    chk("mthi.stall", 32'(mif.stall_req), 32'd0);
    step();
    mif.md_op = MD_MFHI;
    @(negedge clk);
    chk("mfhi.md_out", mif.md_out, 32'h12345678);
    chk("mfhi.busy", 32'(mif.busy), 32'd0);
    chk("mthi.lo_kept", mif.lo, 32'hFFFFFFFE);

    // MTLO then MFLO
    step();
    mif.md_op  = MD_MTLO;
    mif.rs_val = 32'hA5A5A5A5;
    step();
    mif.md_op = MD_MFLO;
    @(negedge clk);
    chk("mflo.md_out", mif.md_out, 32'hA5A5A5A5);
    chk("mtlo.hi_kept", mif.hi, 32'h12345678);
    mif.md_op     = MD_NONE;
    mif.d_uses_md = 1'b0;
    m_hi = 32'h12345678;
    m_lo = 32'hA5A5A5A5;

    // DIV -7 / 2 -> q=-3, r=-1 (or a no-op without the divider)
`ifdef MD_DIV_EN
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, div_busy, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
`else
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, div_busy, m_hi, m_lo, 1'b1, 1'b0);
`endif

    // DIVU by zero: full busy window, HI/LO untouched
    run_op("divu0", MD_DIVU, 32'd100, 32'd0, div_busy, m_hi, m_lo, 1'b1, 1'b0);

    // Unused op code 9 behaves as NONE
    run_op("op9", 4'd9, 32'd5, 32'd7, 0, m_hi, m_lo, 1'b1, 1'b0);

    // MTHI injected mid-MULT is dropped
    run_op("mult_intr", MD_MULT, 32'd7, 32'd6, 5, 32'd0, 32'd42, 1'b1, 1'b1);

    // Random multiplies against a 64-bit reference
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) begin
        pu = {32'd0, ra} * {32'd0, rb};
        run_op("rnd_multu", MD_MULTU, ra, rb, 5, pu[63:32], pu[31:0], 1'b1, 1'b0);
      end else begin
        sa = ra;
        sb = rb;
        ps = longint'(sa) * longint'(sb);
        run_op("rnd_mult", MD_MULT, ra, rb, 5, ps[63:32], ps[31:0], 1'b1, 1'b0);
      end
    end

    // Make HI/LO non-zero so the reset effect is visible
    run_op("pre_abort", MD_MULTU, 32'h00010001, 32'h00010001, 5, 32'h00000001, 32'h00020001, 1'b1, 1'b0);

    // Asynchronous reset in cycle 3 of a long op aborts it
    step();
    mif.md_op  = abort_op;
    mif.rs_val = 32'd1000;
    mif.rt_val = 32'd3;
    step();
    mif.md_op = MD_NONE;
    step();
    step();
    #1;
    chk("abort.busy_before", 32'(mif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.busy_async", 32'(mif.busy), 32'd0);
    chk("abort.hi_async", mif.hi, 32'd0);
    chk("abort.lo_async", mif.lo, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    @(negedge clk);
    chk("abort.busy_after", 32'(mif.busy), 32'd0);
    chk("abort.hi_after", mif.hi, 32'd0);
    chk("abort.lo_after", mif.lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
